regfile_ctrl: RTL and testbench



---
 rtl/regfile_ctrl_if.sv | 26 ++
 rtl/regfile_ctrl.sv | 159 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_if.sv
// Command/response bus of the register-file controller.
// The master issues commands and consumes read responses; the slave is the controller.
interface regfile_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file controller: single WRITE/READ commands, a bulk CLEAR that zeroes
// every register, and a DUMP that streams all registers out as read responses.
// The external register file has a synchronous write port and a combinational read port.
module regfile_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_ctrl_if.slave     bus,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              dump_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              cmd_ready;
  logic              accept;

  assign accept        = bus.cmd_valid && cmd_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;

  // State register; reset aborts any CLEAR or DUMP in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; DUMP reuses READ/RESP and loops until the last register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_WRITE: state_d = S_WRITE;
            OP_READ:  state_d = S_READ;
            OP_CLEAR: state_d = S_CLEAR;
            OP_DUMP:  state_d = S_READ;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = (dump_q && (cnt_q != CNT_MAX)) ? S_READ : S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CNT_MAX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only; cmd_ready is also held low during reset.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = (state_q != S_IDLE);
    rf_we     = 1'b0;
    rf_wAddr  = '0;
    rf_wData  = '0;
    rf_rAddr  = '0;
    case (state_q)
      S_IDLE:  cmd_ready = !reset;
      S_WRITE: begin
        rf_we    = 1'b1;
        rf_wAddr = addr_q;
        rf_wData = data_q;
      end
      S_READ:  rf_rAddr = dump_q ? cnt_q : addr_q;
      S_CLEAR: begin
        rf_we    = 1'b1;
        rf_wAddr = cnt_q;
        rf_wData = '0;
      end
      default: ;
    endcase
  end

  // Command capture, sweep counter, dump flag and the response holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      dump_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q <= bus.cmd_addr;
            data_q <= bus.cmd_data;
            cnt_q  <= '0;
            dump_q <= (bus.cmd_op == OP_DUMP);
          end
        end
        S_READ: begin
          rsp_data_q  <= rf_rData;
          rsp_addr_q  <= rf_rAddr;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // The counter saturates at the last register so a sweep never wraps.
            if (dump_q && (cnt_q != CNT_MAX)) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              dump_q <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural register file attached.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic          rf_we;
  logic [AW-1:0] rf_wAddr;
  logic [DW-1:0] rf_wData;
  logic [AW-1:0] rf_rAddr;
  logic [DW-1:0] rf_rData;

  logic [DW-1:0] regs     [8];
  logic [DW-1:0] exp_dump [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .rf_we    (rf_we),
    .rf_wAddr (rf_wAddr),
    .rf_wData (rf_wData),
    .rf_rAddr (rf_rAddr),
    .rf_rData (rf_rData)
  );

  // Register file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_we) regs[rf_wAddr] <= rf_wData;
  end
  assign rf_rData = regs[rf_rAddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 64'(bus.cmd_ready), 64'd1);
  endtask

  // Offers one command; returns on the falling edge of the first cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Consumes the eight responses of a DUMP, optionally with random back-pressure.
  task automatic collect_dump(input bit rnd);
    int got = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    while (got < 8 && cyc < 500) begin
      if (bus.rsp_valid) begin
        if (hold) begin
          check("dump_hold_addr", 64'(bus.rsp_addr), 64'(pa));
          check("dump_hold_data", 64'(bus.rsp_data), 64'(pd));
        end
        bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.rsp_ready) begin
          check("dump_addr", 64'(bus.rsp_addr), 64'(got));
          check("dump_data", 64'(bus.rsp_data), 64'(exp_dump[got]));
          got++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          pa   = bus.rsp_addr;
          pd   = bus.rsp_data;
        end
      end else begin
        bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rsp_ready = 1'b0;
    check("dump_count", 64'(got), 64'd8);
    for (int i = 0; i < 4; i++) begin
      check("dump_no_extra", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
    end
    check("dump_done_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    check({tag, "_rf_we"},     64'(rf_we),         64'd0);
    check({tag, "_wAddr"},     64'(rf_wAddr),      64'd0);
    check({tag, "_wData"},     64'(rf_wData),      64'd0);
    check({tag, "_rAddr"},     64'(rf_rAddr),      64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_addr"},  64'(bus.rsp_addr),  64'd0);
    check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1;
    check("post_reset_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);

    // Single write then read of register 5.
    send(OP_WRITE, 3'd5, 32'hDEADBEEF);
    check("wr_we",    64'(rf_we),         64'd1);
    check("wr_addr",  64'(rf_wAddr),      64'd5);
    check("wr_data",  64'(rf_wData),      64'hDEADBEEF);
    check("wr_ready", 64'(bus.cmd_ready), 64'd0);
    check("wr_busy",  64'(busy),          64'd1);
    @(negedge clk);
    check("wr_we_off",   64'(rf_we),         64'd0);
    check("wr_ready_on", 64'(bus.cmd_ready), 64'd1);
    send(OP_READ, 3'd5, 32'h0);
    check("rd_valid_early", 64'(bus.rsp_valid), 64'd0);
    check("rd_raddr",       64'(rf_rAddr),      64'd5);
    @(negedge clk);
    check("rd_valid", 64'(bus.rsp_valid), 64'd1);
    check("rd_addr",  64'(bus.rsp_addr),  64'd5);
    check("rd_data",  64'(bus.rsp_data),  64'hDEADBEEF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rd_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("rd_ready_back", 64'(bus.cmd_ready), 64'd1);

    // Fill all registers, then dump under random back-pressure.
    for (int k = 0; k < 8; k++) begin
      send(OP_WRITE, AW'(k), 32'h11111111 * k);
      exp_dump[k] = 32'h11111111 * k;
    end
    send(OP_DUMP, 3'd0, 32'h0);
    collect_dump(1'b1);

    // A command held during a stalled response is taken only after IDLE returns.
    send(OP_READ, 3'd2, 32'h0);
    @(negedge clk);
    check("hold_first_data", 64'(bus.rsp_data), 64'h22222222);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_addr  = 3'd6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.cmd_ready), 64'd0);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_addr",  64'(bus.rsp_addr),  64'd2);
      check("hold_data",  64'(bus.rsp_data),  64'h22222222);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("hold_idle_valid", 64'(bus.rsp_valid), 64'd0);
    check("hold_idle_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("hold_taken_busy",  64'(busy),          64'd1);
    check("hold_taken_raddr", 64'(rf_rAddr),      64'd6);
    @(negedge clk);
    check("hold2_valid", 64'(bus.rsp_valid), 64'd1);
    check("hold2_addr",  64'(bus.rsp_addr),  64'd6);
    check("hold2_data",  64'(bus.rsp_data),  64'h66666666);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("hold2_drop", 64'(bus.rsp_valid), 64'd0);

    // CLEAR sweeps every register once, then a dump reads back zeros.
    send(OP_CLEAR, 3'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("clr_we",    64'(rf_we),         64'd1);
      check("clr_addr",  64'(rf_wAddr),      64'(i));
      check("clr_data",  64'(rf_wData),      64'd0);
      check("clr_ready", 64'(bus.cmd_ready), 64'd0);
      @(negedge clk);
    end
    check("clr_we_off",   64'(rf_we),         64'd0);
    check("clr_ready_on", 64'(bus.cmd_ready), 64'd1);
    for (int k = 0; k < 8; k++) exp_dump[k] = '0;
    send(OP_DUMP, 3'd0, 32'h0);
    collect_dump(1'b0);

    // Reset in the fourth clear cycle leaves registers 3..7 untouched.
    for (int k = 0; k < 8; k++) send(OP_WRITE, AW'(k), 32'hA0 + k);
    send(OP_CLEAR, 3'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("mid_clr_addr", 64'(rf_wAddr), 64'd3);
    reset = 1'b1;
    #1;
    check_all_zero("clr_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("clr_rel_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("clr_rel_we",   64'(rf_we), 64'd0);
    check("clr_rel_busy", 64'(busy),  64'd0);
    for (int k = 0; k < 8; k++) begin
      check("clr_abort_reg", 64'(regs[k]), (k < 3) ? 64'd0 : 64'(32'hA0 + k));
    end

    // Reset while a dump response is pending drops it and does not resume.
    send(OP_DUMP, 3'd0, 32'h0);
    @(negedge clk);
    check("dump_pend_valid", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("dump_rst_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("dump_rst_novalid", 64'(bus.rsp_valid), 64'd0);
    check("dump_rst_idle",    64'(busy),          64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
